// File: rtl/rsa_bridge_pkg.sv
// Shared constants and FSM encoding for the RSA FIFO bridge.
// The optional BUSY watchdog is enabled by defining RSA_BRIDGE_TIMEOUT_EN.
package rsa_bridge_pkg;

  localparam int K_DEFAULT = 128;
  localparam int W_DEFAULT = K_DEFAULT / 32;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_START  = 3'd2,
    ST_BUSY   = 3'd3,
    ST_UNLOAD = 3'd4,
    ST_DONE   = 3'd5
  } state_t;

  function automatic int words_of(input int k);
    return k / 32;
  endfunction

endpackage

// File: rtl/rsa_word_packer.sv
// Shifts 32-bit FIFO words into the three K-bit operands and shifts the
// K-bit engine result back out as 32-bit words, least-significant first.
module rsa_word_packer
  import rsa_bridge_pkg::*;
#(
  parameter int K = K_DEFAULT
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_shift_in,
  input  logic [31:0]  i_word,
  input  logic         i_load_out,
  input  logic [K-1:0] i_result,
  input  logic         i_shift_out,
  output logic [K-1:0] o_base,
  output logic [K-1:0] o_exp,
  output logic [K-1:0] o_mod,
  output logic [31:0]  o_word
);

  logic [3*K-1:0] r_in;
  logic [K-1:0]   r_out;

  // Words enter at the top, so after 3*W shifts the first word sits at bit 0
  // and the stream splits naturally into base | exp | mod.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_in  <= '0;
      r_out <= '0;
    end else begin
      if (i_shift_in) r_in <= {i_word, r_in[3*K-1:32]};
      if (i_load_out) r_out <= i_result;
      else if (i_shift_out) r_out <= r_out >> 32;
    end
  end

  assign o_base = r_in[K-1:0];
  assign o_exp  = r_in[2*K-1:K];
  assign o_mod  = r_in[3*K-1:2*K];
  assign o_word = r_out[31:0];

endmodule

// File: rtl/rsa_fifo_bridge.sv
// Sequences operand loading from a FIFO into an RSA engine and unloads the result.
// Optional BUSY watchdog (sticky err, all-ones result) with RSA_BRIDGE_TIMEOUT_EN.
module rsa_fifo_bridge
  import rsa_bridge_pkg::*;
#(
  parameter int K       = K_DEFAULT,
  parameter int TIMEOUT = 65535
) (
  input  logic         HCLK,
  input  logic         HRESET,
  input  logic         rsa_start,
  output logic         rsa_finish,
  output logic         frd_rdy,
  input  logic         frd_vld,
  input  logic [31:0]  frd_dat,
  output logic         bwr_vld,
  input  logic         bwr_rdy,
  output logic [31:0]  bwr_dat,
  output logic         eng_start,
  output logic [K-1:0] eng_base,
  output logic [K-1:0] eng_exp,
  output logic [K-1:0] eng_mod,
  input  logic         eng_done,
  input  logic [K-1:0] eng_result,
  output logic         busy,
  output logic         err,
  output state_t       dbg_state
);

  localparam int W   = words_of(K);
  localparam int PCW = $clog2(3*W + 1);
  localparam int UCW = $clog2(W + 1);

  if ((K % 32) != 0 || K < 32 || TIMEOUT < 1) begin : g_param_check
    $error("rsa_fifo_bridge: K must be a positive multiple of 32 and TIMEOUT >= 1");
  end

  state_t           r_state;
  logic             r_armed;
  logic [PCW-1:0]   r_pop_cnt;
  logic [UCW-1:0]   r_push_cnt;
  logic             r_frd_rdy;
  logic             r_bwr_vld;
  logic             r_eng_start;
  logic             r_finish;
  logic             w_pop;
  logic             w_push;
  logic             w_load;
  logic             w_timeout;
  logic [K-1:0]     w_load_val;

  // Valid/ready: a word moves only in a cycle where both are high; the bridge
  // never drops rdy/vld once raised until that transfer happens. Reset masks
  // both handshake outputs at once so no transfer completes on the reset edge.
  assign frd_rdy = r_frd_rdy & ~HRESET;
  assign bwr_vld = r_bwr_vld & ~HRESET;
  assign w_pop   = frd_rdy & frd_vld;
  assign w_push  = bwr_vld & bwr_rdy;

`ifdef RSA_BRIDGE_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] r_tmo_cnt;
  logic          r_err;
  assign w_timeout  = (r_state == ST_BUSY) && !eng_done && (r_tmo_cnt == TW'(TIMEOUT - 1));
  assign w_load_val = eng_done ? eng_result : {K{1'b1}};
  assign err        = r_err;
`else
  assign w_timeout  = 1'b0;
  assign w_load_val = eng_result;
  assign err        = 1'b0;
`endif

  assign w_load = ((r_state == ST_BUSY) && eng_done) || w_timeout;

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_state     <= ST_IDLE;
      r_armed     <= 1'b1;
      r_pop_cnt   <= '0;
      r_push_cnt  <= '0;
      r_frd_rdy   <= 1'b0;
      r_bwr_vld   <= 1'b0;
      r_eng_start <= 1'b0;
      r_finish    <= 1'b0;
`ifdef RSA_BRIDGE_TIMEOUT_EN
      r_tmo_cnt   <= '0;
      r_err       <= 1'b0;
`endif
    end else begin
      if (!rsa_start) r_armed <= 1'b1;
      r_finish <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (rsa_start && r_armed) begin
            r_state   <= ST_LOAD;
            r_armed   <= 1'b0;
            r_frd_rdy <= 1'b1;
            r_pop_cnt <= '0;
`ifdef RSA_BRIDGE_TIMEOUT_EN
            r_err     <= 1'b0;
`endif
          end
        end
        ST_LOAD: begin
          if (w_pop) begin
            if (r_pop_cnt == PCW'(3*W - 1)) begin
              r_pop_cnt   <= '0;
              r_frd_rdy   <= 1'b0;
              r_eng_start <= 1'b1;
              r_state     <= ST_START;
            end else begin
              r_pop_cnt <= r_pop_cnt + 1'b1;
            end
          end
        end
        ST_START: begin
          r_eng_start <= 1'b0;
          r_state     <= ST_BUSY;
`ifdef RSA_BRIDGE_TIMEOUT_EN
          r_tmo_cnt   <= '0;
`endif
        end
        ST_BUSY: begin
          if (w_load) begin
            r_state    <= ST_UNLOAD;
            r_bwr_vld  <= 1'b1;
            r_push_cnt <= '0;
`ifdef RSA_BRIDGE_TIMEOUT_EN
            if (w_timeout) r_err <= 1'b1;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
`endif
          end
        end
        ST_UNLOAD: begin
          if (w_push) begin
            if (r_push_cnt == UCW'(W - 1)) begin
              r_push_cnt <= '0;
              r_bwr_vld  <= 1'b0;
              r_finish   <= 1'b1;
              r_state    <= ST_DONE;
            end else begin
              r_push_cnt <= r_push_cnt + 1'b1;
            end
          end
        end
        ST_DONE:  r_state <= ST_IDLE;
        default:  r_state <= ST_IDLE;
      endcase
    end
  end

  rsa_word_packer #(.K(K)) u_packer (
    .i_clk       (HCLK),
    .i_rst       (HRESET),
    .i_shift_in  (w_pop),
    .i_word      (frd_dat),
    .i_load_out  (w_load),
    .i_result    (w_load_val),
    .i_shift_out (w_push),
    .o_base      (eng_base),
    .o_exp       (eng_exp),
    .o_mod       (eng_mod),
    .o_word      (bwr_dat)
  );

  assign eng_start  = r_eng_start;
  assign rsa_finish = r_finish;
  assign busy       = (r_state != ST_IDLE);
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_rsa_fifo_bridge.sv
// Directed bench for rsa_fifo_bridge with K=128; the watchdog section runs
// only when RSA_BRIDGE_TIMEOUT_EN is defined (TIMEOUT=100).
module tb_rsa_fifo_bridge;
  import rsa_bridge_pkg::*;

  localparam int K = 128;

  logic         HCLK;
  logic         HRESET;
  logic         rsa_start;
  logic         rsa_finish;
  logic         frd_rdy;
  logic         frd_vld;
  logic [31:0]  frd_dat;
  logic         bwr_vld;
  logic         bwr_rdy;
  logic [31:0]  bwr_dat;
  logic         eng_start;
  logic [K-1:0] eng_base;
  logic [K-1:0] eng_exp;
  logic [K-1:0] eng_mod;
  logic         eng_done;
  logic [K-1:0] eng_result;
  logic         busy;
  logic         err;
  state_t       dbg_state;

  int n_assert = 0;
  int n_fail   = 0;
  int n_pops   = 0;
  int n_estart = 0;
  int n_fin    = 0;
  int cyc      = 0;
  bit vld_toggle = 1'b0;
  logic [31:0] src_q[$];
  logic [31:0] got_q[$];
  logic [31:0] exp_q[$];

  // clock / reset
  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, observed hang, required finish");
    $fatal(1, "global timeout");
  end

  rsa_fifo_bridge #(.K(K), .TIMEOUT(100)) dut (
    .HCLK       (HCLK),
    .HRESET     (HRESET),
    .rsa_start  (rsa_start),
    .rsa_finish (rsa_finish),
    .frd_rdy    (frd_rdy),
    .frd_vld    (frd_vld),
    .frd_dat    (frd_dat),
    .bwr_vld    (bwr_vld),
    .bwr_rdy    (bwr_rdy),
    .bwr_dat    (bwr_dat),
    .eng_start  (eng_start),
    .eng_base   (eng_base),
    .eng_exp    (eng_exp),
    .eng_mod    (eng_mod),
    .eng_done   (eng_done),
    .eng_result (eng_result),
    .busy       (busy),
    .err        (err),
    .dbg_state  (dbg_state)
  );

  task automatic check(input string tag, input logic [K-1:0] obs, input logic [K-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: record handshakes seen in this cycle, then advance the FIFO source.
  task automatic step();
    #1;
    if (frd_rdy && frd_vld) begin
      n_pops++;
      if (src_q.size() != 0) void'(src_q.pop_front());
    end
    if (bwr_vld && bwr_rdy) got_q.push_back(bwr_dat);
    if (eng_start) n_estart++;
    if (rsa_finish) n_fin++;
    @(posedge HCLK);
    #1;
    cyc++;
    frd_vld = (src_q.size() != 0) && (!vld_toggle || cyc[0]);
    frd_dat = (src_q.size() != 0) ? src_q[0] : 32'h0;
  endtask

  task automatic wait_state(input state_t st, input int budget, input string tag);
    int n = 0;
    while (dbg_state !== st && n < budget) begin
      step();
      n++;
    end
    check(tag, dbg_state, st);
  endtask

  task automatic fill(input logic [31:0] first);
    for (int i = 0; i < 12; i++) src_q.push_back(first + 32'(i));
    frd_dat = src_q[0];
  endtask

  task automatic new_run();
    n_pops = 0;
    n_estart = 0;
    n_fin = 0;
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic check_pushes(input string tag);
    check({tag, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      check($sformatf("%s_w%0d", tag, i), (i < got_q.size()) ? got_q[i] : 32'hx, exp_q[i]);
  endtask

  initial begin
    HRESET = 1'b1; rsa_start = 1'b0; frd_vld = 1'b0; frd_dat = '0;
    bwr_rdy = 1'b1; eng_done = 1'b0; eng_result = '0;
    step(); step();
    check("rst_state", dbg_state, ST_IDLE);
    check("rst_frd_rdy", frd_rdy, 1'b0);
    check("rst_bwr_vld", bwr_vld, 1'b0);
    check("rst_bwr_dat", bwr_dat, 32'h0);
    check("rst_eng_start", eng_start, 1'b0);
    check("rst_eng_base", eng_base, '0);
    check("rst_eng_mod", eng_mod, '0);
    check("rst_finish", rsa_finish, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_err", err, 1'b0);
    HRESET = 1'b0;
    step();

    // eng_done outside BUSY is ignored
    eng_done = 1'b1; eng_result = {4{32'h5A5A5A5A}};
    step();
    eng_done = 1'b0;
    check("idle_ignores_done", dbg_state, ST_IDLE);

    // nominal run, back-to-back pops
    new_run();
    fill(32'h1);
    rsa_start = 1'b1;
    step();
    check("nom_load", dbg_state, ST_LOAD);
    check("nom_frd_rdy", frd_rdy, 1'b1);
    wait_state(ST_START, 20, "nom_reach_start");
    check("nom_pops", n_pops, 12);
    check("nom_eng_start", eng_start, 1'b1);
    check("nom_base", eng_base, 128'h00000004_00000003_00000002_00000001);
    check("nom_exp", eng_exp, 128'h00000008_00000007_00000006_00000005);
    check("nom_mod", eng_mod, 128'h0000000C_0000000B_0000000A_00000009);
    step();
    check("nom_busy", dbg_state, ST_BUSY);
    check("nom_eng_start_low", eng_start, 1'b0);
    check("nom_estart_cycles", n_estart, 1);
    step(); step(); step();
    check("nom_still_busy", dbg_state, ST_BUSY);
    eng_result = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;
    eng_done = 1'b1;
    step();
    eng_done = 1'b0; eng_result = '0;
    check("nom_unload", dbg_state, ST_UNLOAD);
    check("nom_first_word", bwr_dat, 32'hAAAAAAAA);
    check("nom_base_held", eng_base, 128'h00000004_00000003_00000002_00000001);
    exp_q = '{32'hAAAAAAAA, 32'hBBBBBBBB, 32'hCCCCCCCC, 32'hDDDDDDDD};
    step(); step(); step(); step();
    check("nom_done", dbg_state, ST_DONE);
    check("nom_finish", rsa_finish, 1'b1);
    check_pushes("nom_push");
    step();
    check("nom_idle", dbg_state, ST_IDLE);
    check("nom_finish_low", rsa_finish, 1'b0);
    check("nom_finish_cycles", n_fin, 1);

    // re-arm: start still high, no new LOAD
    step(); step(); step();
    check("rearm_hold_idle", dbg_state, ST_IDLE);
    rsa_start = 1'b0;
    step();

    // back-pressure run
    new_run();
    vld_toggle = 1'b1;
    fill(32'h100);
    rsa_start = 1'b1;
    step();
    check("bp_load", dbg_state, ST_LOAD);
    wait_state(ST_START, 60, "bp_reach_start");
    check("bp_pops", n_pops, 12);
    check("bp_base", eng_base, 128'h00000103_00000102_00000101_00000100);
    check("bp_mod", eng_mod, 128'h0000010B_0000010A_00000109_00000108);
    step();
    bwr_rdy = 1'b0;
    eng_result = 128'h44444444_33333333_22222222_11111111;
    eng_done = 1'b1;
    step();
    eng_done = 1'b0;
    check("bp_unload", dbg_state, ST_UNLOAD);
    for (int i = 0; i < 5; i++) begin
      step();
      check($sformatf("bp_stall_vld%0d", i), bwr_vld, 1'b1);
      check($sformatf("bp_stall_dat%0d", i), bwr_dat, 32'h11111111);
    end
    check("bp_no_push_stalled", got_q.size(), 0);
    bwr_rdy = 1'b1;
    exp_q = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
    wait_state(ST_DONE, 10, "bp_reach_done");
    check_pushes("bp_push");
    check("bp_pops_final", n_pops, 12);
    vld_toggle = 1'b0;
    step();
    rsa_start = 1'b0;
    step();

    // reset mid-LOAD after 5 pops
    new_run();
    src_q.delete();
    fill(32'h300);
    rsa_start = 1'b1;
    step();
    for (int i = 0; i < 20 && n_pops < 5; i++) step();
    check("rl_pops_before", n_pops, 5);
    HRESET = 1'b1;
    step();
    check("rl_state", dbg_state, ST_IDLE);
    check("rl_frd_rdy", frd_rdy, 1'b0);
    check("rl_busy", busy, 1'b0);
    check("rl_eng_base", eng_base, '0);
    check("rl_bwr_dat", bwr_dat, 32'h0);
    check("rl_no_extra_pop", n_pops, 5);
    HRESET = 1'b0;
    new_run();
    src_q.delete();
    fill(32'h200);
    step();
    check("rl2_load", dbg_state, ST_LOAD);
    wait_state(ST_START, 20, "rl2_reach_start");
    check("rl2_pops", n_pops, 12);
    check("rl2_base", eng_base, 128'h00000203_00000202_00000201_00000200);
    check("rl2_exp", eng_exp, 128'h00000207_00000206_00000205_00000204);
    check("rl2_mod", eng_mod, 128'h0000020B_0000020A_00000209_00000208);
    step();

`ifdef RSA_BRIDGE_TIMEOUT_EN
    eng_result = 128'h01234567_89ABCDEF_FEDCBA98_76543210;
    eng_done = 1'b1;
    step();
    eng_done = 1'b0;
`else
    for (int i = 0; i < 120; i++) step();
    check("nto_wait_busy", dbg_state, ST_BUSY);
    check("nto_err", err, 1'b0);
    eng_result = 128'h01234567_89ABCDEF_FEDCBA98_76543210;
    eng_done = 1'b1;
    step();
    eng_done = 1'b0;
`endif
    exp_q = '{32'h76543210, 32'hFEDCBA98, 32'h89ABCDEF, 32'h01234567};
    wait_state(ST_DONE, 10, "rl2_reach_done");
    check_pushes("rl2_push");
    step();
    check("rl2_idle", dbg_state, ST_IDLE);
    check("rl2_err", err, 1'b0);

`ifdef RSA_BRIDGE_TIMEOUT_EN
    rsa_start = 1'b0;
    step();
    new_run();
    fill(32'h400);
    rsa_start = 1'b1;
    step();
    wait_state(ST_START, 20, "to_reach_start");
    step();
    for (int i = 0; i < 99; i++) step();
    check("to_busy_99", dbg_state, ST_BUSY);
    check("to_err_99", err, 1'b0);
    step();
    check("to_unload", dbg_state, ST_UNLOAD);
    check("to_err_set", err, 1'b1);
    exp_q = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
    wait_state(ST_DONE, 10, "to_reach_done");
    check_pushes("to_push");
    check("to_finish", rsa_finish, 1'b1);
    step();
    check("to_err_sticky", err, 1'b1);
    rsa_start = 1'b0;
    step();
    rsa_start = 1'b1;
    fill(32'h500);
    step();
    check("to_err_cleared", err, 1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
